// File: rtl/rtc_bus_sequencer.sv
// rtl/rtc_bus_sequencer.sv - multiplexed AD-bus RTC read/write sweep sequencer
// Optional RTC_AUTOPOLL_EN adds a periodic read sweep every POLL_PERIOD clocks.

module rtc_bus_sequencer #(
  parameter int         NREG        = 10,
  parameter int         DW          = 8,
  parameter logic [7:0] ADDR_BASE   = 8'h21,
  parameter int         TPH         = 4,
  parameter int         POLL_PERIOD = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_read,
  input  logic                    wr_req,
  input  logic [NREG*DW-1:0]      wr_data,
  input  logic [NREG-1:0]         wr_mask,
  input  logic [DW-1:0]           ad_in,
  output logic [DW-1:0]           ad_out,
  output logic                    ad_oe,
  output logic                    ale,
  output logic                    cs_n,
  output logic                    rd_n,
  output logic                    wr_n,
  output logic [NREG*DW-1:0]      rd_data,
  output logic                    rd_strobe,
  output logic [$clog2(NREG)-1:0] rd_idx,
  output logic                    busy,
  output logic                    done
);

  localparam int IW = $clog2(NREG);
  localparam int PW = $clog2(TPH);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RECOV, S_NEXT} state_t;

  state_t             state, state_nxt;
  logic [PW-1:0]      phase;
  logic [IW-1:0]      idx, idx_nxt, first_idx;
  logic [NREG-1:0]    rem_mask, snap_mask;
  logic [NREG*DW-1:0] snap_data;
  logic               wr_sweep, pend_wr, poll_req;
  logic               phase_last, start_wr_sweep, start_rd_sweep, wr_accept;
  logic [7:0]         bus_addr;

  assign phase_last     = (phase == PW'(TPH - 1));
  assign bus_addr       = ADDR_BASE + 8'(idx);
  assign start_wr_sweep = (state == S_IDLE) && pend_wr;
  assign start_rd_sweep = (state == S_IDLE) && !pend_wr && (start_read || poll_req);
  // A request is dropped while one is pending or a write sweep owns the snapshot.
  assign wr_accept      = wr_req && !pend_wr && !(wr_sweep && (state != S_IDLE));

  // Lowest still-unwritten masked register; NEXT jumps straight to it.
  always_comb begin
    first_idx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (rem_mask[i]) first_idx = IW'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      phase <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      phase <= ((state_nxt != state) || (state == S_IDLE)) ? '0 : phase + 1'b1;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      S_IDLE: begin
        if (start_wr_sweep) begin
          state_nxt = S_NEXT;
        end else if (start_rd_sweep) begin
          state_nxt = S_ADDR;
          idx_nxt   = '0;
        end
      end
      S_ADDR:  if (phase_last) state_nxt = S_DATA;
      S_DATA:  if (phase_last) state_nxt = S_RECOV;
      S_RECOV: begin
        if (phase_last) begin
          if (wr_sweep) begin
            state_nxt = (|rem_mask) ? S_NEXT : S_IDLE;
          end else if (idx == IW'(NREG - 1)) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_ADDR;
            idx_nxt   = idx + 1'b1;
          end
        end
      end
      S_NEXT: begin
        if (|rem_mask) begin
          state_nxt = S_ADDR;
          idx_nxt   = first_idx;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cs_n   = 1'b1;
    rd_n   = 1'b1;
    wr_n   = 1'b1;
    ale    = 1'b0;
    ad_oe  = 1'b0;
    ad_out = '0;
    busy   = (state != S_IDLE);
    case (state)
      S_ADDR: begin
        cs_n   = 1'b0;
        ale    = 1'b1;
        ad_oe  = 1'b1;
        ad_out = DW'(bus_addr);
      end
      S_DATA: begin
        cs_n = 1'b0;
        if (wr_sweep) begin
          wr_n   = 1'b0;
          ad_oe  = 1'b1;
          ad_out = snap_data[idx*DW +: DW];
        end else begin
          rd_n = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_wr   <= 1'b0;
      wr_sweep  <= 1'b0;
      snap_data <= '0;
      snap_mask <= '0;
      rem_mask  <= '0;
      rd_data   <= '0;
      rd_strobe <= 1'b0;
      rd_idx    <= '0;
      done      <= 1'b0;
    end else begin
      rd_strobe <= 1'b0;
      done      <= (state != S_IDLE) && (state_nxt == S_IDLE);
      if (start_wr_sweep) begin
        pend_wr  <= 1'b0;
        wr_sweep <= 1'b1;
        rem_mask <= snap_mask;
      end else if (wr_accept) begin
        pend_wr   <= 1'b1;
        snap_data <= wr_data;
        snap_mask <= wr_mask;
      end
      if (start_rd_sweep) wr_sweep <= 1'b0;
      if ((state == S_NEXT) && (|rem_mask)) rem_mask[first_idx] <= 1'b0;
      if ((state == S_DATA) && phase_last && !wr_sweep) begin
        rd_data[idx*DW +: DW] <= ad_in;
        rd_strobe             <= 1'b1;
        rd_idx                <= idx;
      end
    end
  end

`ifdef RTC_AUTOPOLL_EN
  localparam int CW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

  logic [CW-1:0] poll_cnt;

  // Expiry wins over a same-cycle sweep start so no period is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      poll_cnt <= CW'(POLL_PERIOD - 1);
      poll_req <= 1'b0;
    end else begin
      poll_cnt <= (poll_cnt == '0) ? CW'(POLL_PERIOD - 1) : poll_cnt - 1'b1;
      if (start_rd_sweep) poll_req <= 1'b0;
      if (poll_cnt == '0) poll_req <= 1'b1;
    end
  end
`else
  assign poll_req = (POLL_PERIOD < 0);
`endif

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// tb/tb_rtc_bus_sequencer.sv - table, directed and random checks of rtc_bus_sequencer

module tb_rtc_bus_sequencer;

  localparam int         NREG = 10;
  localparam int         DW   = 8;
  localparam int         TPH  = 4;
  localparam logic [7:0] BASE = 8'h21;

  logic              clk = 1'b0;
  logic              reset;
  logic              start_read;
  logic              wr_req;
  logic [NREG*DW-1:0] wr_data;
  logic [NREG-1:0]   wr_mask;
  logic [DW-1:0]     ad_in;
  logic [DW-1:0]     ad_out;
  logic              ad_oe, ale, cs_n, rd_n, wr_n;
  logic [NREG*DW-1:0] rd_data;
  logic              rd_strobe;
  logic [3:0]        rd_idx;
  logic              busy, done;

  always #5 clk = ~clk;

  rtc_bus_sequencer #(
    .NREG(NREG), .DW(DW), .ADDR_BASE(BASE), .TPH(TPH), .POLL_PERIOD(200)
  ) dut (
    .clk(clk), .reset(reset), .start_read(start_read), .wr_req(wr_req),
    .wr_data(wr_data), .wr_mask(wr_mask), .ad_in(ad_in), .ad_out(ad_out),
    .ad_oe(ad_oe), .ale(ale), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
    .rd_data(rd_data), .rd_strobe(rd_strobe), .rd_idx(rd_idx),
    .busy(busy), .done(done)
  );

  // RTC chip model: latches the address on ALE, returns mem[] on reads.
  logic [7:0] mem [256];
  logic [7:0] lat_addr = 8'h00;
  always @(posedge clk) if (ale) lat_addr <= ad_out;
  assign ad_in = mem[lat_addr];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [NREG*DW-1:0] model_rd = '0;

  logic [7:0] q_addr[$];
  logic [7:0] q_wdata[$];
  int q_ridx[$];
  int q_rtime[$];
  int obs_cycles, obs_wait, proto_err;
  bit any_cs, any_rd, any_wr, obs_timeout;

  int               inj_at[2] = '{-1, -1};
  logic [79:0]      inj_data[2];
  logic [9:0]       inj_mask[2];

  function automatic int sweep_len(input bit is_read, input logic [9:0] mask);
    int n = $countones(mask);
    if (is_read) return 3 * TPH * NREG;
    return (n == 0) ? 1 : n * (3 * TPH + 1);
  endfunction

  task automatic fill_mem(input int mode);
    for (int a = 0; a < 256; a++) begin
      logic [7:0] av = 8'(a);
      case (mode)
        1: mem[a] = av + 8'h10;
        2: mem[a] = ~av;
        default: mem[a] = 8'($urandom_range(0, 255));
      endcase
    end
  endtask

  // trig: 0 = just watch, 1 = pulse start_read, 2 = pulse wr_req
  task automatic observe(input int trig, input logic [79:0] tdata, input logic [9:0] tmask);
    bit prev_ale = 1'b0;
    bit prev_wr  = 1'b1;
    bit seen     = 1'b0;
    int n = 0;
    int bc = 0;
    int rel;
    q_addr.delete(); q_wdata.delete(); q_ridx.delete(); q_rtime.delete();
    obs_wait = 0; proto_err = 0; obs_timeout = 0;
    any_cs = 0; any_rd = 0; any_wr = 0;
    while (1) begin
      @(negedge clk);
      if (busy) begin bc++; seen = 1'b1; end
      else if (!seen) obs_wait++;
      rel = bc - 1;
      if (ale && !prev_ale) q_addr.push_back(ad_out);
      if (!wr_n && prev_wr) q_wdata.push_back(ad_out);
      if (rd_strobe) begin q_ridx.push_back(int'(rd_idx)); q_rtime.push_back(rel); end
      if (!cs_n) any_cs = 1'b1;
      if (!rd_n) any_rd = 1'b1;
      if (!wr_n) any_wr = 1'b1;
      if ((!rd_n && ad_oe) || (!rd_n && !wr_n) || (ale && cs_n) || (busy && done)) proto_err++;
      prev_ale = ale;
      prev_wr  = wr_n;
      start_read = 1'b0;
      wr_req     = 1'b0;
      if (done) break;
      if (n == 0 && trig == 1) start_read = 1'b1;
      if (n == 0 && trig == 2) begin wr_req = 1'b1; wr_data = tdata; wr_mask = tmask; end
      for (int k = 0; k < 2; k++) begin
        if (busy && rel == inj_at[k]) begin
          wr_req = 1'b1; wr_data = inj_data[k]; wr_mask = inj_mask[k];
        end
      end
      n++;
      if (n > 3000) begin obs_timeout = 1'b1; break; end
    end
    obs_cycles = bc;
  endtask

  task automatic check_sweep(input string tag, input bit is_read, input logic [9:0] mask,
                             input logic [79:0] data, input int exp_cycles);
    logic [7:0] ea[$];
    logic [7:0] ed[$];
    for (int i = 0; i < NREG; i++) begin
      logic [7:0] a = BASE + 8'(i);
      if (is_read) begin
        ea.push_back(a);
        model_rd[i*DW +: DW] = mem[a];
      end else if (mask[i]) begin
        ea.push_back(a);
        ed.push_back(data[i*DW +: DW]);
      end
    end
    chk($sformatf("%s timeout", tag), obs_timeout, 0);
    chk($sformatf("%s cycles", tag), obs_cycles, exp_cycles);
    chk($sformatf("%s n_addr", tag), q_addr.size(), ea.size());
    for (int i = 0; i < ea.size() && i < q_addr.size(); i++)
      chk($sformatf("%s addr%0d", tag, i), q_addr[i], ea[i]);
    chk($sformatf("%s n_wdata", tag), q_wdata.size(), ed.size());
    for (int i = 0; i < ed.size() && i < q_wdata.size(); i++)
      chk($sformatf("%s wdata%0d", tag, i), q_wdata[i], ed[i]);
    chk($sformatf("%s n_strobe", tag), q_ridx.size(), is_read ? NREG : 0);
    for (int i = 0; i < q_ridx.size(); i++) begin
      chk($sformatf("%s ridx%0d", tag, i), q_ridx[i], i);
      chk($sformatf("%s rtime%0d", tag, i), q_rtime[i], 3 * TPH * i + 2 * TPH);
    end
    chk($sformatf("%s any_rd", tag), any_rd, is_read);
    chk($sformatf("%s any_wr", tag), any_wr, !is_read && (mask != 0));
    chk($sformatf("%s any_cs", tag), any_cs, is_read || (mask != 0));
    chk($sformatf("%s protocol", tag), proto_err, 0);
    chk($sformatf("%s rd_data", tag), rd_data, model_rd);
  endtask

  typedef struct {
    bit          is_read;
    int          mem_mode;
    logic [9:0]  mask;
    logic [79:0] data;
    int          exp_cycles;
    logic [7:0]  exp_s0;
    logic [7:0]  exp_s9;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 1, 10'h000, 80'h0, 120, 8'h31, 8'h3A};
    vecs[1] = '{1'b0, 0, 10'b0000000110, {56'hDEADBEEF0BADF0, 8'h03, 8'h15, 8'hEE}, 26, 8'h31, 8'h3A};
    vecs[2] = '{1'b0, 0, 10'h000, 80'h5555_5555_5555_5555_5555, 1, 8'h31, 8'h3A};
    vecs[3] = '{1'b0, 0, 10'h200, {8'hC7, 72'h0}, 13, 8'h31, 8'h3A};
    vecs[4] = '{1'b0, 0, 10'h3FF, 80'h1122_3344_5566_7788_99AA, 130, 8'h31, 8'h3A};
    vecs[5] = '{1'b1, 2, 10'h000, 80'h0, 120, 8'hDE, 8'hD5};

    reset = 1'b1; start_read = 1'b0; wr_req = 1'b0; wr_data = '0; wr_mask = '0;
    fill_mem(1);
    repeat (3) @(negedge clk);
    chk("reset ctrl", {cs_n, rd_n, wr_n, ale, ad_oe, rd_strobe, busy, done}, 8'b1110_0000);
    chk("reset ad_out", ad_out, 0);
    chk("reset rd_data", rd_data, 0);
    chk("reset rd_idx", rd_idx, 0);
    reset = 1'b0;

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].mem_mode != 0) fill_mem(vecs[v].mem_mode);
      observe(vecs[v].is_read ? 1 : 2, vecs[v].data, vecs[v].mask);
      check_sweep($sformatf("vec%0d", v), vecs[v].is_read, vecs[v].mask, vecs[v].data,
                  vecs[v].exp_cycles);
      chk($sformatf("vec%0d slice0", v), rd_data[7:0], vecs[v].exp_s0);
      chk($sformatf("vec%0d slice9", v), rd_data[79:72], vecs[v].exp_s9);
    end

    // Write requested at register 4 of a read sweep, plus a second one that must be ignored.
    fill_mem(0);
    inj_at[0] = 3 * TPH * 4; inj_data[0] = 80'hA1A2_A3A4_A5A6_A7A8_A9AA; inj_mask[0] = 10'h2A5;
    inj_at[1] = 3 * TPH * 5; inj_data[1] = 80'h0102_0304_0506_0708_090A; inj_mask[1] = 10'h3FF;
    observe(1, '0, '0);
    inj_at[0] = -1; inj_at[1] = -1;
    check_sweep("inj read", 1'b1, '0, '0, 120);
    observe(0, '0, '0);
    chk("inj wr_follows", obs_wait, 0);
    check_sweep("inj write", 1'b0, 10'h2A5, 80'hA1A2_A3A4_A5A6_A7A8_A9AA, sweep_len(1'b0, 10'h2A5));
    repeat (3) @(negedge clk);
    chk("inj no_extra_sweep", busy, 0);

    for (int r = 0; r < 10; r++) begin
      bit          rd = 1'($urandom_range(0, 1));
      logic [9:0]  m  = ($urandom_range(0, 5) == 0) ? 10'h0 : 10'($urandom_range(0, 1023));
      logic [79:0] d  = {16'($urandom), $urandom, $urandom};
      if (rd) fill_mem(0);
      observe(rd ? 1 : 2, d, m);
      check_sweep($sformatf("rnd%0d", r), rd, m, d, sweep_len(rd, m));
    end

    // Reset in the middle of a write data phase.
    @(negedge clk);
    wr_req = 1'b1; wr_data = {80{1'b1}}; wr_mask = 10'h010;
    @(negedge clk);
    wr_req = 1'b0;
    for (int t = 0; t < 60 && wr_n; t++) @(negedge clk);
    chk("rst reached wr_n low", wr_n, 0);
    #2 reset = 1'b1;
    #1;
    chk("rst bus idle", {wr_n, cs_n, ad_oe, ale, rd_n}, 5'b11001);
    chk("rst rd_data", rd_data, 0);
    chk("rst busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    model_rd = '0;
    begin
      bit saw_busy = 1'b0;
      repeat (20) begin
        @(negedge clk);
        if (busy) saw_busy = 1'b1;
      end
      chk("rst no_retry", saw_busy, 0);
    end
    fill_mem(0);
    observe(1, '0, '0);
    check_sweep("post_rst read", 1'b1, '0, '0, 120);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
